// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM states and default sizing.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;

  // Beat counter width; large enough for bursts of up to 15 beats.
  localparam int CNT_W = 4;

  // Width of a requester index; at least one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating-priority picker: one-hot select of the first request at or after rr_ptr.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick
);

  // Walk the requesters starting at rr_ptr, wrapping, and keep the first hit.
  always_comb begin
    logic found;
    int   idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a shared FIFO; grants bursts of up to
// MAX_BURST beats and can clear the FIFO on request.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    last,
  input  logic [N_REQ*DW-1:0] data,
  input  logic                flush,
  input  logic                fifo_full,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic                fifo_wren,
  output logic [DW-1:0]       fifo_din,
  output logic                fifo_sclr
);

  localparam int PW = ptr_w(N_REQ);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt, pick;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [PW-1:0]    rr_ptr, rr_nxt, gnt_idx, ptr_after;
  logic             beat, req_k, last_k;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  // Resolve the granted requester's index and its req/last bits.
  always_comb begin
    gnt_idx = '0;
    req_k   = 1'b0;
    last_k  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PW'(i);
        req_k   = req[i];
        last_k  = last[i];
      end
    end
    ptr_after = PW'((int'(gnt_idx) + 1) % N_REQ);
    cnt_inc   = cnt + CNT_W'(1);
  end

  // A beat moves one word into the FIFO; flush and a full FIFO both suppress it.
  always_comb begin
    beat      = (state == BURST) && req_k && !fifo_full && !flush;
    fifo_wren = beat;
    ack       = beat ? gnt : '0;
    fifo_sclr = (state == FLUSH);
    fifo_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (beat && gnt[i]) fifo_din = data[i*DW +: DW];
    end
  end

  // Next-state logic: arbitration in IDLE, burst termination, flush priority.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (flush) begin
          state_nxt = FLUSH;
        end else if (|req) begin
          state_nxt = BURST;
          gnt_nxt   = pick;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (flush) begin
          state_nxt = FLUSH;
          gnt_nxt   = '0;
        end else if (!req_k) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          rr_nxt    = ptr_after;
        end else if (beat) begin
          cnt_nxt = cnt_inc;
          if (last_k || (cnt_inc == CNT_W'(MAX_BURST))) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            rr_nxt    = ptr_after;
          end
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State, grant, beat count and priority pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb with default parameters.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, last;
  logic [31:0] data;
  logic        flush, fifo_full;
  logic [3:0]  gnt, ack;
  logic        fifo_wren;
  logic [7:0]  fifo_din;
  logic        fifo_sclr;

  int total_checks = 0;
  int bad_checks   = 0;

  fifo_wr_arb #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .data      (data),
    .flush     (flush),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .ack       (ack),
    .fifo_wren (fifo_wren),
    .fifo_din  (fifo_din),
    .fifo_sclr (fifo_sclr)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic fl, input logic ff);
    req       = r;
    last      = l;
    flush     = fl;
    fifo_full = ff;
    #1;
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task checkBeat(input string tag, input logic [3:0] exp_gnt, input logic exp_wren,
                 input logic [7:0] exp_din);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    checkOutput({tag, "_wren"}, 32'(fifo_wren), 32'(exp_wren));
    checkOutput({tag, "_ack"}, 32'(ack), exp_wren ? 32'(exp_gnt) : 32'd0);
    checkOutput({tag, "_din"}, 32'(fifo_din), 32'(exp_din));
  endtask

  task pulseReset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    data  = '0;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    #2;
    checkBeat("rst", 4'b0000, 1'b0, 8'h00);
    checkOutput("rst_sclr", 32'(fifo_sclr), 32'd0);
    checkOutput("rst_ptr", 32'(dut.rr_ptr), 32'd0);
    tick;
    reset = 1'b0;

    // Single requester, three beats ending on last.
    data[7:0] = 8'h11;
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
    checkOutput("t1_idle_gnt", 32'(gnt), 32'd0);
    tick;
    checkBeat("t1_b1", 4'b0001, 1'b1, 8'h11);
    tick;
    data[7:0] = 8'h22;
    #1;
    checkBeat("t1_b2", 4'b0001, 1'b1, 8'h22);
    tick;
    data[7:0] = 8'h33;
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    checkBeat("t1_b3", 4'b0001, 1'b1, 8'h33);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    checkBeat("t1_end", 4'b0000, 1'b0, 8'h00);
    checkOutput("t1_ptr", 32'(dut.rr_ptr), 32'd1);

    // Round robin with all requesters active, bursts capped at 4 beats.
    tick;
    pulseReset;
    data = 32'hA3A2A1A0;
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    checkOutput("t2_idle_gnt", 32'(gnt), 32'd0);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        tick;
        checkBeat($sformatf("t2_g%0d_b%0d", g, b), 4'(1 << (g % 4)), 1'b1,
                  8'(8'hA0 + (g % 4)));
      end
      tick;
      checkOutput($sformatf("t2_gap%0d_gnt", g), 32'(gnt), 32'd0);
      checkOutput($sformatf("t2_gap%0d_wren", g), 32'(fifo_wren), 32'd0);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Backpressure on requester 2 after its first beat.
    tick;
    pulseReset;
    data = 32'h00C20000;
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
    tick;
    checkBeat("t3_b1", 4'b0100, 1'b1, 8'hC2);
    for (int i = 0; i < 3; i++) begin
      tick;
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1);
      checkBeat($sformatf("t3_full%0d", i), 4'b0100, 1'b0, 8'h00);
    end
    for (int b = 0; b < 3; b++) begin
      tick;
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
      checkBeat($sformatf("t3_b%0d", b + 2), 4'b0100, 1'b1, 8'hC2);
    end
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("t3_end_gnt", 32'(gnt), 32'd0);
    checkOutput("t3_ptr", 32'(dut.rr_ptr), 32'd3);

    // Flush on the second beat of requester 1.
    tick;
    pulseReset;
    data[7:0] = 8'h55;
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    tick;
    checkBeat("t4_pre", 4'b0001, 1'b1, 8'h55);
    tick;
    data[15:8] = 8'h66;
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
    checkOutput("t4_pre_ptr", 32'(dut.rr_ptr), 32'd1);
    tick;
    checkBeat("t4_b1", 4'b0010, 1'b1, 8'h66);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    checkBeat("t4_flush", 4'b0010, 1'b0, 8'h00);
    checkOutput("t4_flush_sclr", 32'(fifo_sclr), 32'd0);
    tick;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("t4_sclr", 32'(fifo_sclr), 32'd1);
    checkOutput("t4_sclr_gnt", 32'(gnt), 32'd0);
    tick;
    checkOutput("t4_after_sclr", 32'(fifo_sclr), 32'd0);
    checkOutput("t4_ptr", 32'(dut.rr_ptr), 32'd1);

    // Held flush alternates FLUSH/IDLE and never grants.
    applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput($sformatf("t5_sclr%0d", i), 32'(fifo_sclr), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t5_gnt%0d", i), 32'(gnt), 32'd0);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("t5_ptr", 32'(dut.rr_ptr), 32'd1);

    // Requester 3 drops its request after one beat.
    data[31:24] = 8'h77;
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
    tick;
    checkBeat("t6_b1", 4'b1000, 1'b1, 8'h77);
    tick;
    applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
    checkBeat("t6_drop", 4'b1000, 1'b0, 8'h00);
    tick;
    checkOutput("t6_idle_gnt", 32'(gnt), 32'd0);
    checkOutput("t6_ptr", 32'(dut.rr_ptr), 32'd0);
    tick;
    data[7:0] = 8'h99;
    #1;
    checkBeat("t6_next", 4'b0001, 1'b1, 8'h99);

    // Asynchronous reset in the middle of a burst.
    tick;
    reset = 1'b1;
    #1;
    checkBeat("t7_rst", 4'b0000, 1'b0, 8'h00);
    checkOutput("t7_rst_sclr", 32'(fifo_sclr), 32'd0);
    applyStimulus(4'b1100, 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("t7_rel_gnt", 32'(gnt), 32'd0);
    tick;
    checkBeat("t7_first", 4'b0100, 1'b1, 8'hC2);
    checkOutput("t7_sclr", 32'(fifo_sclr), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
